// File: rtl/if_id_pipe.sv
// rtl/if_id_pipe.sv - IF/ID boundary register with valid/ready, flush and optional skid entry
module if_id_pipe #(
    parameter int                 INSTR_W = 32,
    parameter int                 PC_W    = 64,
    parameter logic [INSTR_W-1:0] NOP     = 32'h00000013,
    parameter int                 SKID    = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [PC_W-1:0]    in_pc_plus4,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [PC_W-1:0]    out_pc_plus4,
    output logic [1:0]         occupancy
);

    // Main entry drives out_* directly; it is loaded with NOP/0 whenever it
    // goes invalid so bubbles come straight from flops with no output mux.
    logic               main_valid_q, main_valid_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [PC_W-1:0]    main_pc4_q, main_pc4_d;

    // Skid entry holds the second beat (always younger than main).
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [PC_W-1:0]    skid_pc4_q, skid_pc4_d;

    // Registered ready, used only in the skid build.
    logic               in_ready_q, in_ready_d;

    logic               accept;
    logic               drain;

    assign in_ready     = (SKID != 0) ? in_ready_q : (!main_valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    assign drain        = main_valid_q && out_ready;

    assign out_valid    = main_valid_q;
    assign out_instr    = main_instr_q;
    assign out_pc       = main_pc_q;
    assign out_pc_plus4 = main_pc4_q;
    assign occupancy    = skid_valid_q ? 2'd2 : (main_valid_q ? 2'd1 : 2'd0);

    // Next-state for both entries: flush empties everything, otherwise
    // EMPTY/ONE/TWO transitions keep beats in arrival order.
    always_comb begin
        main_valid_d = main_valid_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        main_pc4_d   = main_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;

        if (flush) begin
            main_valid_d = 1'b0;
            main_instr_d = NOP;
            main_pc_d    = '0;
            main_pc4_d   = '0;
            skid_valid_d = 1'b0;
            skid_instr_d = NOP;
            skid_pc_d    = '0;
            skid_pc4_d   = '0;
        end else if (skid_valid_q) begin
            // TWO: ready is low, only a drain can move things
            if (drain) begin
                main_valid_d = 1'b1;
                main_instr_d = skid_instr_q;
                main_pc_d    = skid_pc_q;
                main_pc4_d   = skid_pc4_q;
                skid_valid_d = 1'b0;
                skid_instr_d = NOP;
                skid_pc_d    = '0;
                skid_pc4_d   = '0;
            end
        end else if (main_valid_q) begin
            // ONE
            if (accept && drain) begin
                main_instr_d = in_instr;
                main_pc_d    = in_pc;
                main_pc4_d   = in_pc_plus4;
            end else if (accept && (SKID != 0)) begin
                skid_valid_d = 1'b1;
                skid_instr_d = in_instr;
                skid_pc_d    = in_pc;
                skid_pc4_d   = in_pc_plus4;
            end else if (drain) begin
                main_valid_d = 1'b0;
                main_instr_d = NOP;
                main_pc_d    = '0;
                main_pc4_d   = '0;
            end
        end else if (accept) begin
            // EMPTY
            main_valid_d = 1'b1;
            main_instr_d = in_instr;
            main_pc_d    = in_pc;
            main_pc4_d   = in_pc_plus4;
        end

        in_ready_d = !skid_valid_d;
    end

    // State registers; reset clears both entries and holds ready low.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_instr_q <= NOP;
            main_pc_q    <= '0;
            main_pc4_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            main_pc4_q   <= main_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            in_ready_q   <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// tb/tb_if_id_pipe.sv - directed table plus random scoreboard for if_id_pipe
module tb_if_id_pipe;

    localparam logic [31:0] NOPI = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic [63:0] in_pc_plus4;
    logic        flush;
    logic        out_ready;

    logic        in_ready1, out_valid1;
    logic [31:0] out_instr1;
    logic [63:0] out_pc1, out_pc4_1;
    logic [1:0]  occ1;

    logic        in_ready0, out_valid0;
    logic [31:0] out_instr0;
    logic [63:0] out_pc0, out_pc4_0;
    logic [1:0]  occ0;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    if_id_pipe #(.INSTR_W(32), .PC_W(64), .NOP(32'h00000013), .SKID(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_instr(in_instr), .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_instr(out_instr1),
        .out_pc(out_pc1), .out_pc_plus4(out_pc4_1), .occupancy(occ1)
    );

    if_id_pipe #(.INSTR_W(32), .PC_W(64), .NOP(32'h00000013), .SKID(0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_instr(in_instr), .in_pc(in_pc), .in_pc_plus4(in_pc_plus4), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_instr(out_instr0),
        .out_pc(out_pc0), .out_pc_plus4(out_pc4_0), .occupancy(occ0)
    );

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        fl;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic [1:0]  e_occ;
        logic        e_ir;
        logic        chk0;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } beat_t;

    vec_t  tbl[18];
    beat_t q1[$];
    beat_t q0[$];

    function automatic vec_t mk(logic iv, logic [31:0] instr, logic [63:0] pc, logic fl,
                                logic ordy, logic e_ov, logic [31:0] e_instr,
                                logic [63:0] e_pc, logic [1:0] e_occ, logic e_ir, logic chk0);
        vec_t v;
        v.iv = iv; v.instr = instr; v.pc = pc; v.fl = fl; v.ordy = ordy;
        v.e_ov = e_ov; v.e_instr = e_instr; v.e_pc = e_pc; v.e_occ = e_occ;
        v.e_ir = e_ir; v.chk0 = chk0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] instr, input logic [63:0] pc,
                         input logic fl, input logic ordy);
        in_valid    = iv;
        in_instr    = instr;
        in_pc       = pc;
        in_pc_plus4 = pc + 64'd4;
        flush       = fl;
        out_ready   = ordy;
    endtask

    // {valid, instr, pc, pc+4, occupancy, in_ready} of the skid instance
    function automatic logic [191:0] obs1();
        return {28'd0, out_valid1, out_instr1, out_pc1, out_pc4_1, occ1, in_ready1};
    endfunction

    function automatic logic [191:0] obs0_no_ir();
        return {28'd0, out_valid0, out_instr0, out_pc0, out_pc4_0, occ0, 1'b0};
    endfunction

    function automatic logic [191:0] expv(logic ov, logic [31:0] ins, logic [63:0] pc,
                                          logic [1:0] occ, logic ir);
        logic [63:0] p4;
        p4 = ov ? pc + 64'd4 : 64'd0;
        return {28'd0, ov, ins, pc, p4, occ, ir};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        logic [31:0] ri;
        logic [63:0] rp;
        logic        riv, rfl, ror, m_ir, ir0, acc1, dr1, acc0, dr0;
        beat_t       b;

        // directed table: inputs applied before an edge, outputs checked after it
        tbl[0]  = mk(1, 32'h00500093, 64'h0,   0, 1, 1, 32'h00500093, 64'h0,   2'd1, 1, 1);
        tbl[1]  = mk(1, 32'h00A00113, 64'h4,   0, 1, 1, 32'h00A00113, 64'h4,   2'd1, 1, 1);
        tbl[2]  = mk(1, 32'h002081B3, 64'h8,   0, 1, 1, 32'h002081B3, 64'h8,   2'd1, 1, 1);
        tbl[3]  = mk(1, 32'h00000013, 64'hC,   0, 1, 1, 32'h00000013, 64'hC,   2'd1, 1, 1);
        tbl[4]  = mk(0, 32'h0,        64'h0,   0, 1, 0, NOPI,         64'h0,   2'd0, 1, 1);
        tbl[5]  = mk(1, 32'h11111111, 64'h100, 0, 1, 1, 32'h11111111, 64'h100, 2'd1, 1, 0);
        tbl[6]  = mk(1, 32'h22222222, 64'h104, 0, 0, 1, 32'h11111111, 64'h100, 2'd2, 0, 0);
        tbl[7]  = mk(1, 32'h33333333, 64'h108, 0, 0, 1, 32'h11111111, 64'h100, 2'd2, 0, 0);
        tbl[8]  = mk(1, 32'h33333333, 64'h108, 0, 1, 1, 32'h22222222, 64'h104, 2'd1, 1, 0);
        tbl[9]  = mk(1, 32'h33333333, 64'h108, 0, 1, 1, 32'h33333333, 64'h108, 2'd1, 1, 0);
        tbl[10] = mk(0, 32'h0,        64'h0,   0, 1, 0, NOPI,         64'h0,   2'd0, 1, 0);
        tbl[11] = mk(1, 32'h44444444, 64'h200, 0, 0, 1, 32'h44444444, 64'h200, 2'd1, 1, 0);
        tbl[12] = mk(1, 32'h55555555, 64'h204, 0, 0, 1, 32'h44444444, 64'h200, 2'd2, 0, 0);
        tbl[13] = mk(1, 32'h66666666, 64'h208, 1, 0, 0, NOPI,         64'h0,   2'd0, 1, 0);
        tbl[14] = mk(0, 32'h0,        64'h0,   0, 1, 0, NOPI,         64'h0,   2'd0, 1, 0);
        tbl[15] = mk(1, 32'h77777777, 64'h300, 0, 1, 1, 32'h77777777, 64'h300, 2'd1, 1, 0);
        tbl[16] = mk(1, 32'h88888888, 64'h304, 1, 1, 0, NOPI,         64'h0,   2'd0, 1, 0);
        tbl[17] = mk(0, 32'h0,        64'h0,   0, 1, 0, NOPI,         64'h0,   2'd0, 1, 0);

        // reset state, including ready held low while reset is high
        reset = 1'b1;
        drive(1'b0, 32'h0, 64'h0, 1'b0, 1'b1);
        step();
        step();
        chk("reset_state", obs1(), expv(0, NOPI, 64'h0, 2'd0, 0));
        reset = 1'b0;
        step();
        chk("ready_after_reset", obs1(), expv(0, NOPI, 64'h0, 2'd0, 1));

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].iv, tbl[i].instr, tbl[i].pc, tbl[i].fl, tbl[i].ordy);
            step();
            chk($sformatf("vec%0d", i), obs1(),
                expv(tbl[i].e_ov, tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_occ, tbl[i].e_ir));
            if (tbl[i].chk0)
                chk($sformatf("vec%0d_noskid", i), obs0_no_ir(),
                    expv(tbl[i].e_ov, tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_occ, 1'b0)
                    & ~192'd1);
        end

        // reset with occupancy=2 and flush/handshakes in the same cycle
        drive(1, 32'hAAAA0001, 64'h400, 0, 0);
        step();
        drive(1, 32'hAAAA0002, 64'h404, 0, 0);
        step();
        chk("fill_two", obs1(), expv(1, 32'hAAAA0001, 64'h400, 2'd2, 0));
        reset = 1'b1;
        drive(1, 32'hAAAA0003, 64'h408, 1, 1);
        step();
        chk("mid_reset", obs1(), expv(0, NOPI, 64'h0, 2'd0, 0));
        reset = 1'b0;
        drive(0, 32'h0, 64'h0, 0, 1);
        step();
        chk("mid_reset_ready", obs1(), expv(0, NOPI, 64'h0, 2'd0, 1));
        drive(1, 32'hBBBB0001, 64'h500, 0, 1);
        step();
        chk("post_reset_beat", obs1(), expv(1, 32'hBBBB0001, 64'h500, 2'd1, 1));
        drive(0, 32'h0, 64'h0, 0, 1);
        step();
        chk("post_reset_empty", obs1(), expv(0, NOPI, 64'h0, 2'd0, 1));

        // random traffic against queue models of both builds
        do_reset();
        q1.delete();
        q0.delete();
        m_ir = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            riv = ($urandom_range(0, 3) != 0);
            ror = ($urandom_range(0, 2) != 0);
            rfl = ($urandom_range(0, 31) == 0);
            ri  = $urandom;
            rp  = {$urandom, $urandom};
            drive(riv, ri, rp, rfl, ror);
            ir0  = (q0.size() == 0) || ror;
            acc1 = riv && m_ir;
            dr1  = (q1.size() != 0) && ror;
            acc0 = riv && ir0;
            dr0  = (q0.size() != 0) && ror;
            #1;
            chk($sformatf("rnd%0d_ready0", c), {191'd0, in_ready0}, {191'd0, ir0});
            @(posedge clk);
            b.instr = ri;
            b.pc    = rp;
            if (rfl) begin
                q1.delete();
                q0.delete();
            end else begin
                if (dr1) void'(q1.pop_front());
                if (acc1) q1.push_back(b);
                if (dr0) void'(q0.pop_front());
                if (acc0) q0.push_back(b);
            end
            m_ir = (q1.size() < 2);
            #1;
            if (q1.size() != 0)
                chk($sformatf("rnd%0d_skid", c), obs1(),
                    expv(1, q1[0].instr, q1[0].pc, 2'(q1.size()), m_ir));
            else
                chk($sformatf("rnd%0d_skid", c), obs1(), expv(0, NOPI, 64'h0, 2'd0, m_ir));
            if (q0.size() != 0)
                chk($sformatf("rnd%0d_noskid", c), obs0_no_ir(),
                    expv(1, q0[0].instr, q0[0].pc, 2'd1, 0));
            else
                chk($sformatf("rnd%0d_noskid", c), obs0_no_ir(), expv(0, NOPI, 64'h0, 2'd0, 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
